// File: rtl/id_token_extractor_if.sv
// Character-stream input and token-record output of id_token_extractor.
// The character source and token consumer share this bundle; clk/reset stay outside.
interface id_token_extractor_if #(
   parameter int unsigned LEN_W = 5,
   parameter int unsigned CNT_W = 8
);
   logic [7:0]       char;
   logic             char_valid;
   logic             char_last;
   logic             char_ready;
   logic             tok_valid;
   logic             tok_ready;
   logic [CNT_W-1:0] tok_start;
   logic [LEN_W-1:0] tok_len;
   logic             tok_trunc;
   logic [CNT_W-1:0] id_count;

   modport master (
      output char, char_valid, char_last, tok_ready,
      input  char_ready, tok_valid, tok_start, tok_len, tok_trunc, id_count
   );

   modport slave (
      input  char, char_valid, char_last, tok_ready,
      output char_ready, tok_valid, tok_start, tok_len, tok_trunc, id_count
   );
endinterface

// File: rtl/id_token_extractor.sv
// Splits an ASCII stream into words and emits (start, len, trunc) for each identifier
// through a one-entry valid/ready buffer that backpressures the character source.
module id_token_extractor #(
   parameter int unsigned MAX_LEN = 16,
   parameter int unsigned LEN_W   = 5,
   parameter int unsigned CNT_W   = 8
)(
   input logic                 clk,
   input logic                 reset,
   id_token_extractor_if.slave bus
);
   typedef enum logic [1:0] {IDLE, IN_ID, SKIP} state_t;

   localparam logic [LEN_W-1:0] LP_MAX = LEN_W'(MAX_LEN);

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_pos, r_start, w_start_nxt;
   logic [LEN_W-1:0] r_len, w_len_nxt;
   logic             r_trunc, w_trunc_nxt;
   logic             w_emit;

   logic             r_tok_valid, r_tok_trunc;
   logic [CNT_W-1:0] r_tok_start, r_id_count;
   logic [LEN_W-1:0] r_tok_len;

   logic w_char_ready, w_accept, w_letter, w_digit, w_alnum;

   assign w_char_ready = ~r_tok_valid | bus.tok_ready;
   assign w_accept     = bus.char_valid & w_char_ready;
   assign w_letter     = (bus.char >= 8'd65 && bus.char <= 8'd90) ||
                         (bus.char >= 8'd97 && bus.char <= 8'd122);
   assign w_digit      = (bus.char >= 8'd48 && bus.char <= 8'd57);
   assign w_alnum      = w_letter | w_digit;

   always_comb begin
      w_state_nxt = r_state;
      w_start_nxt = r_start;
      w_len_nxt   = r_len;
      w_trunc_nxt = r_trunc;
      w_emit      = 1'b0;
      if (w_accept) begin
         case (r_state)
            IDLE: begin
               if (w_letter) begin
                  w_state_nxt = IN_ID;
                  w_start_nxt = r_pos;
                  w_len_nxt   = LEN_W'(1);
                  w_trunc_nxt = 1'b0;
               end else if (w_digit) begin
                  w_state_nxt = SKIP;
               end
            end
            IN_ID: begin
               if (w_alnum) begin
                  if (r_len == LP_MAX) w_trunc_nxt = 1'b1;
                  else                 w_len_nxt   = r_len + LEN_W'(1);
               end else begin
                  w_emit      = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
            SKIP: begin
               if (!w_alnum) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
         // The final character is classified first, so a trailing letter/digit joins the token.
         if (bus.char_last) begin
            if (w_state_nxt == IN_ID) w_emit = 1'b1;
            w_state_nxt = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_pos       <= '0;
         r_start     <= '0;
         r_len       <= '0;
         r_trunc     <= 1'b0;
         r_tok_valid <= 1'b0;
         r_tok_start <= '0;
         r_tok_len   <= '0;
         r_tok_trunc <= 1'b0;
         r_id_count  <= '0;
      end else begin
         if (w_accept) begin
            r_state <= w_state_nxt;
            r_start <= w_start_nxt;
            r_len   <= w_len_nxt;
            r_trunc <= w_trunc_nxt;
            r_pos   <= bus.char_last ? '0 : r_pos + CNT_W'(1);
         end
         if (w_emit) begin
            r_tok_valid <= 1'b1;
            r_tok_start <= w_start_nxt;
            r_tok_len   <= w_len_nxt;
            r_tok_trunc <= w_trunc_nxt;
            r_id_count  <= r_id_count + CNT_W'(1);
         end else if (r_tok_valid && bus.tok_ready) begin
            r_tok_valid <= 1'b0;
         end
      end
   end

   assign bus.char_ready = w_char_ready;
   assign bus.tok_valid  = r_tok_valid;
   assign bus.tok_start  = r_tok_start;
   assign bus.tok_len    = r_tok_len;
   assign bus.tok_trunc  = r_tok_trunc;
   assign bus.id_count   = r_id_count;
endmodule

// File: doc/id_token_extractor.md
Name: id_token_extractor

Overview:
Sits in parallel with id_fsm on the same 8-bit ASCII character stream and acts as its downstream consumer.
- Segments the stream into words.
- Classifies each word as an identifier (a letter followed by letters or digits) or not.
- Emits one token record per identifier: start position, length, truncation flag.
- Records leave through a one-entry valid/ready output buffer with backpressure to the character source.

Parameters:
MAX_LEN, 16, identifier length saturation value; must be <= 2^LEN_W - 1
LEN_W, 5, width of tok_len
CNT_W, 8, width of the position counter and identifier counter

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
char  input  8  ASCII character
char_valid  input  1  char is presented this cycle
char_last  input  1  qualifies char as the final character of the stream; valid only with char_valid
char_ready  output  1  block accepts char this cycle; combinational: ~tok_valid | tok_ready
tok_valid  output  1  token record held in the output buffer
tok_ready  input  1  consumer takes the record this cycle
tok_start  output  CNT_W  stream position of the identifier's first character
tok_len  output  LEN_W  identifier length, saturated at MAX_LEN
tok_trunc  output  1  identifier was longer than MAX_LEN
id_count  output  CNT_W  number of tokens loaded into the buffer since reset; wraps

Behaviour:
Character acceptance and classes
- A character is accepted when char_valid & char_ready.
- Classes: letter = 65..90 or 97..122; digit = 48..57; separator = everything else.
- pos (internal, CNT_W bits) is the position of the current accepted character.
- pos increments per accepted character, wraps 2^CNT_W-1 -> 0, and resets to 0 after an accepted char_last.

States (internal, reset to IDLE)
- IDLE, on accepted char:
  - letter -> IN_ID; len=1, start=pos.
  - digit -> SKIP.
  - separator -> IDLE.
- IN_ID, on accepted char:
  - letter/digit -> IN_ID; len=min(len+1, MAX_LEN); trunc set when len was already MAX_LEN.
  - separator -> emit; go to IDLE.
- SKIP, on accepted char:
  - letter/digit -> SKIP.
  - separator -> IDLE. No emission.
- An accepted char_last is processed by its class first; then:
  - if the resulting state is IN_ID, emit a token that includes that character;
  - next state is IDLE in all cases.

Emission
- At the accepting clock edge, load tok_start/tok_len/tok_trunc, set tok_valid, and increment id_count. tok_valid is high the following cycle (latency 1).
- The separator that terminates a token is not counted in tok_len.

Output buffer
- The record and tok_valid are held stable until tok_valid & tok_ready.
- Pop alone: tok_valid clears next cycle. Record fields keep their last values.
- Pop and a new emission in the same cycle: buffer is replaced and tok_valid stays 1 (no bubble).
- char_ready is low only while tok_valid & ~tok_ready. Input stalls regardless of the class of the pending char; state and pos do not change while stalled.

Reset (synchronous, active-high)
- Outputs: tok_valid=0, tok_start=0, tok_len=0, tok_trunc=0, id_count=0.
- Internal: state IDLE, pos=0, len=0, trunc=0.
- Reset mid-token discards the partial token. Reset overrides any simultaneous accept or pop.

Test Plan:
- "ab1 x9" with char_last on '9', tok_ready=1: two tokens; (start=0, len=3, trunc=0) one cycle after ' ' is accepted; (start=4, len=2) one cycle after '9'; id_count=2 at end.
- "9ab c." with tok_ready=1: one token only, (start=4, len=1), emitted on '.'; "9ab" produces nothing; id_count=1.
- 20 letters then ' ', MAX_LEN=16: tok_len=16, tok_trunc=1, start=0. Next identifier "q " yields tok_trunc=0.
- Backpressure: tok_ready=0 after the "a " token, then drive "b ":
  - char_ready drops the cycle after the first token loads, holding 'b' (pos 2);
  - first record stays stable for 5 cycles;
  - raise tok_ready: first record accepted; 'b' is accepted that cycle;
  - ' ' is then accepted and (start=2, len=1) appears with no bubble cycle.
- Assert reset for one cycle while in IN_ID after "abc", then send " d ": no token for "abc"; single token (start=1, len=1), id_count=1.
- Stream of 300 separators then "z " with CNT_W=8: pos wraps; token start=(300 mod 256)=44, len=1.
